tb_clk_monitor: RTL and testbench
=================================

# tb_clk_monitor

Testbench-side clock checker: the receiving end of the generated clock. It oversamples a monitored clock (`mon_clk`) in the bench reference clock domain and measures its period and high time in reference cycles. It declares lock after a run of in-range periods and flags period violations and stalls. It sits beside clock generators in the bench, so clock-generation setup errors are caught in hardware rather than by waveform inspection.

## Interface
- `CNT_W`, 16: width of period/high-time counters; saturating.
- `PERIOD_MIN`, 2: smallest legal period, in reference cycles, inclusive.
- `PERIOD_MAX`, 65535: largest legal period, inclusive.
- `STALL_LIMIT`, 1024: reference cycles without a rising edge before a stall is flagged.
- `LOCK_COUNT`, 4: consecutive in-range periods required for lock.

Ports:
- `clock` in 1: reference clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run the monitor; 0 forces IDLE.
- `clear_err` in 1: clears the sticky error flags.
- `mon_clk` in 1: monitored clock, asynchronous to `clock`.
- `period` out CNT_W: last measured period.
- `high_time` out CNT_W: last measured high phase.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `locked` out 1: lock indication.
- `err_period` out 1: sticky out-of-range flag.
- `err_stall` out 1: sticky stall flag.
- `edge_count` out 32: count of rising edges since enable; wraps.

## Operation
- **Synchroniser:** `mon_clk` passes through 2 flops (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- **State machine:** IDLE, ACQUIRE, MEASURE, LOCKED.
  - IDLE: counters cleared, `locked`=0. Moves to ACQUIRE when `enable`=1.
  - ACQUIRE: waits for the first rise. That rise starts the period counter, produces no `period_valid`, and moves to MEASURE.
  - MEASURE: each rise latches `period`, pulses `period_valid` and increments a good-run counter if the period is in [PERIOD_MIN, PERIOD_MAX]. When the good-run counter reaches LOCK_COUNT, move to LOCKED.
  - LOCKED: each rise latches and pulses as in MEASURE. An out-of-range period returns to MEASURE.
  - Any out-of-range period sets `err_period`, zeroes the good-run counter and drops `locked`.
  - Stall: a stall counter increments each cycle without a rise in ACQUIRE, MEASURE or LOCKED. When it reaches STALL_LIMIT: set `err_stall`, `locked`=0, go to ACQUIRE, clear the good-run counter.
  - `enable`=0 in any state: go to IDLE next cycle. `period`, `high_time` and the error flags hold their values; `edge_count` clears.
- **Period counter:** loads 1 on a rise, otherwise increments, saturating at 2^CNT_W-1. A saturated value is reported as-is and is out of range if it exceeds PERIOD_MAX.
- **High-time counter:** loads 1 on a rise and increments while s2=1, saturating. Its value is latched into `high_time` on a fall; the first fall after ACQUIRE is ignored.
- **Error flags:** set-dominant. A set event in the same cycle as `clear_err` leaves the flag set.
- **edge_count:** increments on every rise in ACQUIRE, MEASURE and LOCKED.

## Timing
- Reset values: `period`=0, `high_time`=0, `period_valid`=0, `locked`=0, `err_period`=0, `err_stall`=0, `edge_count`=0, state=IDLE.
- Latency: if s1 first samples `mon_clk` high at `clock` edge k, then rise is true in cycle k+1 to k+2 and `period`/`period_valid`/`edge_count` update at edge k+2.
  - `locked` rises at the same edge as the `period_valid` of the LOCK_COUNT-th good period.
- `period_valid` is high for exactly one cycle per reported rise. It is never asserted in IDLE or ACQUIRE.
- A stall is flagged at the edge where the stall count reaches STALL_LIMIT. A rise in that same cycle takes priority: no stall.
- `mon_clk` pulses shorter than one `clock` period may be missed. This is legal behaviour, not an error; the period monitor must run ≥2× faster than the monitored clock.
- `reset` mid-operation: all outputs reach their reset values asynchronously. Operation restarts from IDLE after deassertion.

## Test plan
- **Lock:** `mon_clk` period 10 `clock` cycles, 50% duty; PERIOD_MIN=8, PERIOD_MAX=12, LOCK_COUNT=4 -> `period`=10 and `high_time`=5 on every pulse; `locked`=1 at the 5th rise; no errors.
- **Period violation:** from LOCKED, one period of 14 -> `err_period`=1 and `locked`=0 at that pulse. Four more 10-cycle periods -> `locked`=1 again; `err_period` stays 1.
- **Stall:** STALL_LIMIT=64; hold `mon_clk` low after lock -> `err_stall`=1 and `locked`=0 exactly 64 cycles after the last rise is detected; state returns to ACQUIRE; the next rise gives no `period_valid`.
- **Clear collision:** assert `clear_err` in the same cycle as a new out-of-range period -> `err_period` remains 1. A `clear_err` one cycle later -> `err_period`=0.
- **Saturation:** CNT_W=4, `mon_clk` period 20 -> `period`=15 and `err_period`=1.
- **Reset and enable:** assert `reset` mid-measurement -> all outputs are 0 immediately. Drop `enable` after lock -> `locked`=0 and `edge_count`=0; `period` is held.

Source files
------------

// File: rtl/tb_clk_monitor.sv
// tb_clk_monitor: oversamples mon_clk in the reference clock domain, measures its
// period and high time, and reports lock, out-of-range periods and stalls.
module tb_clk_monitor #(
   parameter int          CNT_W       = 16,
   parameter int unsigned PERIOD_MIN  = 2,
   parameter int unsigned PERIOD_MAX  = 65535,
   parameter int unsigned STALL_LIMIT = 1024,
   parameter int unsigned LOCK_COUNT  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear_err,
   input  logic             mon_clk,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             err_period,
   output logic             err_stall,
   output logic [31:0]      edge_count
);
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);
   localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [STALL_W-1:0] STALL_TOP = STALL_W'(STALL_LIMIT - 1);
   localparam logic [GOOD_W-1:0]  GOOD_TOP  = GOOD_W'(LOCK_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACQUIRE,
      ST_MEASURE,
      ST_LOCKED
   } state_t;

   state_t             state;
   logic               s1, s2, s3;
   logic               rise, fall;
   logic               in_range, stall_hit;
   logic [CNT_W-1:0]   pcnt, hcnt;
   logic [STALL_W-1:0] stall_cnt;
   logic [GOOD_W-1:0]  good_run;

   assign rise      = s2 & ~s3;
   assign fall      = ~s2 & s3;
   assign in_range  = (64'(pcnt) >= 64'(PERIOD_MIN)) && (64'(pcnt) <= 64'(PERIOD_MAX));
   assign stall_hit = (stall_cnt == STALL_TOP) && !rise;

   // NOTE: non-blocking assignments make s1 -> s2 -> s3 advance exactly one flop per edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= mon_clk;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         pcnt         <= '0;
         hcnt         <= '0;
         stall_cnt    <= '0;
         good_run     <= '0;
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         err_period   <= 1'b0;
         err_stall    <= 1'b0;
         edge_count   <= '0;
      end else begin
         period_valid <= 1'b0;
         // Set events below override the clear, so the flags are set-dominant.
         err_period   <= err_period & ~clear_err;
         err_stall    <= err_stall & ~clear_err;

         if (!enable) begin
            state      <= ST_IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            stall_cnt  <= '0;
            good_run   <= '0;
            locked     <= 1'b0;
            edge_count <= '0;
         end else if (state == ST_IDLE) begin
            state     <= ST_ACQUIRE;
            pcnt      <= '0;
            hcnt      <= '0;
            stall_cnt <= '0;
            good_run  <= '0;
         end else begin
            if (rise) begin
               pcnt       <= CNT_ONE;
               hcnt       <= CNT_ONE;
               stall_cnt  <= '0;
               edge_count <= edge_count + 32'd1;
            end else begin
               if (pcnt != CNT_MAX) pcnt <= pcnt + CNT_ONE;
               if (s2 && hcnt != CNT_MAX) hcnt <= hcnt + CNT_ONE;
               stall_cnt <= stall_hit ? '0 : stall_cnt + 1'b1;
            end

            // A fall seen in ACQUIRE closes a high phase that began before we started counting.
            if (fall && state != ST_ACQUIRE) high_time <= hcnt;

            case (state)
               ST_ACQUIRE: begin
                  if (rise) begin
                     state    <= ST_MEASURE;
                     good_run <= '0;
                  end else if (stall_hit) begin
                     err_stall <= 1'b1;
                  end
               end
               ST_MEASURE, ST_LOCKED: begin
                  if (rise) begin
                     period       <= pcnt;
                     period_valid <= 1'b1;
                     if (!in_range) begin
                        err_period <= 1'b1;
                        good_run   <= '0;
                        locked     <= 1'b0;
                        state      <= ST_MEASURE;
                     end else if (state == ST_MEASURE) begin
                        good_run <= good_run + 1'b1;
                        if (good_run == GOOD_TOP) begin
                           state  <= ST_LOCKED;
                           locked <= 1'b1;
                        end
                     end
                  end else if (stall_hit) begin
                     err_stall <= 1'b1;
                     locked    <= 1'b0;
                     good_run  <= '0;
                     state     <= ST_ACQUIRE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tb_clk_monitor.sv
// Bench for tb_clk_monitor: a timestamp-based model is compared with the DUT every
// cycle, and directed scenarios add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_tb_clk_monitor;
   localparam int CNT_W = 16;
   localparam int PMIN  = 8;
   localparam int PMAX  = 12;
   localparam int STALL = 64;
   localparam int LOCKN = 4;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clock = 1'b0, reset = 1'b1, enable = 1'b0, clear_err = 1'b0, mon_clk = 1'b0;
   logic [CNT_W-1:0] period, high_time;
   logic period_valid, locked, err_period, err_stall;
   logic [31:0] edge_count;

   logic enable_s = 1'b0, mon_s = 1'b0;
   logic [3:0] period_s, high_s;
   logic pv_s, locked_s, errp_s, errs_s;
   logic [31:0] edges_s;

   int errors = 0, checks = 0;

   always #5 clock = ~clock;

   tb_clk_monitor #(
      .CNT_W(CNT_W), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX),
      .STALL_LIMIT(STALL), .LOCK_COUNT(LOCKN)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .clear_err(clear_err),
      .mon_clk(mon_clk), .period(period), .high_time(high_time),
      .period_valid(period_valid), .locked(locked), .err_period(err_period),
      .err_stall(err_stall), .edge_count(edge_count)
   );

   tb_clk_monitor #(
      .CNT_W(4), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX),
      .STALL_LIMIT(1024), .LOCK_COUNT(LOCKN)
   ) dut_s (
      .clock(clock), .reset(reset), .enable(enable_s), .clear_err(clear_err),
      .mon_clk(mon_s), .period(period_s), .high_time(high_s),
      .period_valid(pv_s), .locked(locked_s), .err_period(errp_s),
      .err_stall(errs_s), .edge_count(edges_s)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: rises/falls become timestamps two edges after mon_clk is first sampled at a
   // new level; periods and high times are differences of those timestamps.
   typedef enum {M_IDLE, M_ACQ, M_RUN} mphase_t;
   mphase_t phase = M_IDLE;
   int cyc = 0, last_rise = 0, last_act = 0, good = 0, m_p = 0;
   bit prev_samp = 1'b0, m_rise, m_fall, m_setp, m_sets;
   int rise_q[$], fall_q[$];
   int e_period = 0, e_high = 0, e_edges = 0;
   bit e_pv = 1'b0, e_locked = 1'b0, e_errp = 1'b0, e_errs = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         phase = M_IDLE; prev_samp = 1'b0; good = 0;
         rise_q.delete(); fall_q.delete();
         e_period = 0; e_high = 0; e_edges = 0;
         e_pv = 1'b0; e_locked = 1'b0; e_errp = 1'b0; e_errs = 1'b0;
      end else begin
         cyc++;
         if (mon_clk && !prev_samp) rise_q.push_back(cyc + 2);
         if (!mon_clk && prev_samp) fall_q.push_back(cyc + 2);
         prev_samp = mon_clk;
         m_rise = 1'b0; m_fall = 1'b0; m_setp = 1'b0; m_sets = 1'b0;
         while (rise_q.size() > 0 && rise_q[0] <= cyc) begin
            m_rise = (rise_q[0] == cyc);
            void'(rise_q.pop_front());
         end
         while (fall_q.size() > 0 && fall_q[0] <= cyc) begin
            m_fall = (fall_q[0] == cyc);
            void'(fall_q.pop_front());
         end
         e_pv = 1'b0;
         if (!enable) begin
            phase = M_IDLE; e_locked = 1'b0; e_edges = 0;
         end else if (phase == M_IDLE) begin
            phase = M_ACQ; last_act = cyc;
         end else begin
            if (m_rise) e_edges++;
            if (phase == M_ACQ) begin
               if (m_rise) begin
                  phase = M_RUN; good = 0; last_rise = cyc; last_act = cyc;
               end else if (cyc - last_act == STALL) begin
                  m_sets = 1'b1; last_act = cyc;
               end
            end else begin
               if (m_fall) e_high = (cyc - last_rise > SAT) ? SAT : cyc - last_rise;
               if (m_rise) begin
                  m_p = (cyc - last_rise > SAT) ? SAT : cyc - last_rise;
                  e_period = m_p; e_pv = 1'b1;
                  last_rise = cyc; last_act = cyc;
                  if (m_p >= PMIN && m_p <= PMAX) begin
                     good++;
                     if (good >= LOCKN) e_locked = 1'b1;
                  end else begin
                     m_setp = 1'b1; good = 0; e_locked = 1'b0;
                  end
               end else if (cyc - last_act == STALL) begin
                  m_sets = 1'b1; e_locked = 1'b0; good = 0;
                  phase = M_ACQ; last_act = cyc;
               end
            end
         end
         e_errp = m_setp | (e_errp & !clear_err);
         e_errs = m_sets | (e_errs & !clear_err);
      end
   end

   int pv_seen = 0, last_pv_cyc = 0, stall_cyc = 0;
   bit prev_errs = 1'b0;

   always @(posedge clock) begin
      #1;
      check("period", period, e_period);
      check("high_time", high_time, e_high);
      check("period_valid", period_valid, e_pv);
      check("locked", locked, e_locked);
      check("err_period", err_period, e_errp);
      check("err_stall", err_stall, e_errs);
      check("edge_count", edge_count, e_edges);
      if (period_valid) begin
         pv_seen++;
         last_pv_cyc = cyc;
      end
      if (err_stall && !prev_errs) stall_cyc = cyc;
      prev_errs = err_stall;
   end

   // Called just after a negedge; returns just after a negedge.
   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse(input int hi, input int lo);
      mon_clk = 1'b1;
      idle(hi);
      mon_clk = 1'b0;
      idle(lo);
   endtask

   int base_pv, base_edges;

   initial begin
      idle(2);
      check("rst_period", period, 0);
      check("rst_high", high_time, 0);
      check("rst_pv", period_valid, 0);
      check("rst_locked", locked, 0);
      check("rst_errp", err_period, 0);
      check("rst_errs", err_stall, 0);
      check("rst_edges", edge_count, 0);
      reset = 1'b0;
      idle(2);
      enable = 1'b1;
      idle(3);

      // Lock: four good 10-cycle periods after the acquiring rise.
      repeat (5) pulse(5, 5);
      check("lock_locked", locked, 1);
      check("lock_period", period, 10);
      check("lock_high", high_time, 5);
      check("lock_edges", edge_count, 5);
      check("lock_errp", err_period, 0);

      // Period violation: one 14-cycle period, then relock.
      pulse(7, 7);
      pulse(5, 5);
      check("viol_errp", err_period, 1);
      check("viol_locked", locked, 0);
      check("viol_period", period, 14);
      repeat (4) pulse(5, 5);
      check("relock_locked", locked, 1);
      check("relock_errp", err_period, 1);

      // Clear collision: clear_err coincides with an out-of-range report, then one cycle later.
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      check("clr_errp", err_period, 0);
      pulse(8, 8);
      mon_clk = 1'b1;
      idle(2);
      clear_err = 1'b1;
      idle(1);
      check("coll_errp", err_period, 1);
      check("coll_period", period, 16);
      check("coll_locked", locked, 0);
      idle(1);
      clear_err = 1'b0;
      check("clr2_errp", err_period, 0);
      idle(1);
      mon_clk = 1'b0;
      idle(5);
      repeat (5) pulse(5, 5);
      check("relock2_locked", locked, 1);

      // Stall: hold mon_clk low.
      idle(STALL + 16);
      check("stall_errs", err_stall, 1);
      check("stall_locked", locked, 0);
      check("stall_gap", stall_cyc - last_pv_cyc, STALL);
      base_pv = pv_seen;
      base_edges = edge_count;
      pulse(5, 5);
      check("stall_no_pv", pv_seen - base_pv, 0);
      check("stall_edges", edge_count - base_edges, 1);
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      check("stall_clr", err_stall, 0);

      // Reset in the middle of a measurement.
      pulse(5, 5);
      pulse(5, 5);
      mon_clk = 1'b1;
      idle(3);
      #2 reset = 1'b1;
      #1;
      check("rstmid_period", period, 0);
      check("rstmid_high", high_time, 0);
      check("rstmid_edges", edge_count, 0);
      check("rstmid_locked", locked, 0);
      check("rstmid_pv", period_valid, 0);
      @(negedge clock);
      reset = 1'b0;
      mon_clk = 1'b0;
      idle(3);

      // Enable drop after lock.
      repeat (5) pulse(5, 5);
      check("en_prelock", locked, 1);
      enable = 1'b0;
      idle(1);
      check("en_locked", locked, 0);
      check("en_edges", edge_count, 0);
      check("en_period", period, 10);

      // Saturation on the 4-bit instance: 20-cycle period reports 15.
      enable_s = 1'b1;
      idle(3);
      repeat (3) begin
         mon_s = 1'b1;
         idle(10);
         mon_s = 1'b0;
         idle(10);
      end
      check("sat_period", period_s, 15);
      check("sat_errp", errp_s, 1);
      check("sat_high", high_s, 10);
      check("sat_locked", locked_s, 0);
      check("sat_edges", edges_s, 3);

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
